// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
// Contents:
//   pc_src_t             - next-PC source select encoding
//   RESET_VECTOR_DEFAULT - default PC after reset
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2,
        PC_SRC_RET    = 2'd3
    } pc_src_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with a top pointer and a saturating entry count.
// When full, a push silently overwrites the oldest entry.
// All state changes happen on the falling edge of clk_i.
// Ports:
//   clk_i, rst_ni - clock, synchronous active-low reset (clears pointer and count)
//   push_i        - write data_i at top+1 and advance top
//   pop_i         - retreat top (caller guarantees non-empty)
//   replace_i     - overwrite the current top entry with data_i
//   data_i        - entry to write
//   top_o         - current top entry
//   count_o       - number of valid entries
module ras_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             replace_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] top_q, top_d, wr_idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             we;

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign wr_idx = push_i ? top_q + PTR_W'(1) : top_q;
    assign we     = push_i | replace_i;

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        if (push_i) begin
            top_d = top_q + PTR_W'(1);
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_i) begin
            top_d   = top_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(negedge clk_i) begin
        if (!rst_ni) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    // Entry contents are not reset; a write is suppressed while reset is asserted.
    always_ff @(negedge clk_i) begin
        if (rst_ni && we) begin
            mem_q[wr_idx] <= data_i;
        end
    end

    assign top_o   = mem_q[top_q];
    assign count_o = count_q;

endmodule

// File: rtl/pc_ras_unit.sv
// Program-counter unit with next-PC mux, stall support and a return-address stack.
// All state updates on the falling edge of clk_i; reset is synchronous, active-low.
// Ports:
//   clk_i, rst_ni   - clock, synchronous active-low reset
//   stall_i         - hold PC and RAS
//   pc_src_i        - next-PC select (SEQ, BRANCH, JUMP, RET)
//   call_i          - push PC+INSTR_BYTES (with BRANCH/JUMP) or swap top (with RET)
//   imm_ext_i       - sign-extended branch offset
//   jump_target_i   - absolute jump target (low two bits ignored)
//   pc_o            - current PC
//   ras_count_o     - valid RAS entries
//   ras_full_o      - RAS holds RAS_DEPTH entries
//   ras_empty_o     - RAS holds no entries
//   ras_underflow_o - one-cycle pulse after a RET with an empty RAS
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEFAULT),
    parameter int unsigned          RAS_DEPTH    = 4,
    parameter int unsigned          INSTR_BYTES  = 4,
    localparam int unsigned         CNT_W        = $clog2(RAS_DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stall_i,
    input  logic [1:0]          pc_src_i,
    input  logic                call_i,
    input  logic [PC_WIDTH-1:0] imm_ext_i,
    input  logic [PC_WIDTH-1:0] jump_target_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [CNT_W-1:0]    ras_count_o,
    output logic                ras_full_o,
    output logic                ras_empty_o,
    output logic                ras_underflow_o
);

    localparam logic [PC_WIDTH-1:0] INC = PC_WIDTH'(INSTR_BYTES);

    pc_src_t             src;
    logic [PC_WIDTH-1:0] pc_q, pc_d, seq_pc, ras_top;
    logic                uf_q, uf_d;
    logic                push, pop, replace;

    assign src    = pc_src_t'(pc_src_i);
    assign seq_pc = pc_q + INC;

    always_comb begin
        pc_d    = pc_q;
        uf_d    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        replace = 1'b0;
        if (!stall_i) begin
            unique case (src)
                PC_SRC_SEQ: pc_d = seq_pc;
                PC_SRC_BRANCH: begin
                    pc_d = pc_q + imm_ext_i;
                    push = call_i;
                end
                PC_SRC_JUMP: begin
                    pc_d = {jump_target_i[PC_WIDTH-1:2], 2'b00};
                    push = call_i;
                end
                PC_SRC_RET: begin
                    if (ras_empty_o) begin
                        pc_d = seq_pc;
                        uf_d = 1'b1;
                        push = call_i;
                    end else begin
                        // call with RET swaps the top entry instead of popping it.
                        pc_d    = ras_top;
                        replace = call_i;
                        pop     = !call_i;
                    end
                end
                default: pc_d = seq_pc;
            endcase
        end
    end

    always_ff @(negedge clk_i) begin
        if (!rst_ni) begin
            pc_q <= RESET_VECTOR;
            uf_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            uf_q <= uf_d;
        end
    end

    ras_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push),
        .pop_i     (pop),
        .replace_i (replace),
        .data_i    (seq_pc),
        .top_o     (ras_top),
        .count_o   (ras_count_o)
    );

    assign pc_o            = pc_q;
    assign ras_full_o      = ras_count_o == CNT_W'(RAS_DEPTH);
    assign ras_empty_o     = ras_count_o == '0;
    assign ras_underflow_o = uf_q;

endmodule
